// File: rtl/msg_pkg.sv
// Shared types and message table contents for the message sequencer.
// Each message is two ROM segments {start, len}; add messages by editing MSG_ROM only.
package msg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_TICK,
    ST_DELAY,
    ST_SEND,
    ST_WAIT_TX
  } state_t;

  localparam int MSG_SEL_W = 4;
  localparam int MSG_CNT   = 1 << MSG_SEL_W;

  typedef struct packed {
    logic [7:0] start;
    logic [7:0] len;
  } seg_t;

  typedef struct packed {
    seg_t s0;
    seg_t s1;
  } msg_t;

  // {start0, len0, start1, len1}; a zero length skips that segment.
  localparam msg_t MSG_ROM [MSG_CNT] = '{
    {8'd0,  8'd0,  8'd0,  8'd0},
    {8'd0,  8'd13, 8'd0,  8'd0},
    {8'd62, 8'd4,  8'd0,  8'd0},
    {8'd13, 8'd6,  8'd0,  8'd0},
    {8'd20, 8'd4,  8'd40, 8'd3},
    {8'd0,  8'd0,  8'd45, 8'd2},
    {8'd50, 8'd5,  8'd0,  8'd0},
    {8'd24, 8'd3,  8'd24, 8'd3},
    {8'd60, 8'd2,  8'd2,  8'd2},
    {8'd0,  8'd13, 8'd32, 8'd5},
    {8'd32, 8'd5,  8'd0,  8'd13},
    {8'd19, 8'd1,  8'd0,  8'd0},
    {8'd0,  8'd0,  8'd0,  8'd0},
    {8'd8,  8'd8,  8'd56, 8'd8},
    {8'd37, 8'd2,  8'd63, 8'd3},
    {8'd1,  8'd1,  8'd2,  8'd1}
  };

endpackage

// File: rtl/msg_table.sv
// Combinational selector-to-segments lookup; zero latency, no flow control.
// Codes beyond the table return an empty message.
module msg_table
  import msg_pkg::*;
#(
  parameter int SEL_W  = 4,
  parameter int ADDR_W = 6,
  parameter int LEN_W  = 6
) (
  input  logic [SEL_W-1:0]  sel,
  output logic [ADDR_W-1:0] start0,
  output logic [LEN_W-1:0]  len0,
  output logic [ADDR_W-1:0] start1,
  output logic [LEN_W-1:0]  len1
);

  msg_t entry;

  always_comb begin
    entry = '0;
    if ((sel >> MSG_SEL_W) == '0) begin
      entry = MSG_ROM[MSG_SEL_W'(sel)];
    end
  end

  assign start0 = ADDR_W'(entry.s0.start);
  assign len0   = LEN_W'(entry.s0.len);
  assign start1 = ADDR_W'(entry.s1.start);
  assign len1   = LEN_W'(entry.s1.len);

endmodule

// File: rtl/msg_sequencer.sv
// Launches a selected two-segment message and emits it one ROM character per char_tick.
// First tx_start comes START_DLY+2 cycles or more after launch; each character waits for tx_busy to clear.
module msg_sequencer
  import msg_pkg::*;
#(
  parameter int SEL_W     = 4,
  parameter int ADDR_W    = 6,
  parameter int LEN_W     = 6,
  parameter int START_DLY = 3
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic              active,
  input  logic [SEL_W-1:0]  sel,
  input  logic              send,
  input  logic              auto_btn,
  input  logic              auto_tick,
  input  logic              char_tick,
  input  logic              tx_busy,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              tx_start,
  output logic              busy,
  output logic              done,
  output logic              auto_on
);

  localparam int DLY_W = (START_DLY < 1) ? 1 : $clog2(START_DLY + 1);

  logic [ADDR_W-1:0] tbl_start0, tbl_start1;
  logic [LEN_W-1:0]  tbl_len0, tbl_len1;
  logic [LEN_W:0]    tbl_total;

  logic [ADDR_W-1:0] start0, start1;
  logic [LEN_W-1:0]  len0;
  logic [LEN_W:0]    total;
  logic [LEN_W:0]    idx;
  logic [ADDR_W-1:0] char_addr;
  logic [DLY_W-1:0]  dly;
  logic              seen_busy;
  logic              empty_pend;
  logic              launch;
  state_t            state;

  msg_table #(
    .SEL_W (SEL_W),
    .ADDR_W(ADDR_W),
    .LEN_W (LEN_W)
  ) u_table (
    .sel   (sel),
    .start0(tbl_start0),
    .len0  (tbl_len0),
    .start1(tbl_start1),
    .len1  (tbl_len1)
  );

  assign launch    = send | (auto_tick & auto_on);
  assign tbl_total = {1'b0, tbl_len0} + {1'b0, tbl_len1};

  // Address arithmetic wraps naturally at ADDR_W bits.
  always_comb begin
    char_addr = start1 + ADDR_W'(idx - {1'b0, len0});
    if (idx < {1'b0, len0}) begin
      char_addr = start0 + ADDR_W'(idx);
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      rom_addr   <= '0;
      tx_start   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      auto_on    <= 1'b0;
      idx        <= '0;
      dly        <= '0;
      seen_busy  <= 1'b0;
      empty_pend <= 1'b0;
      start0     <= '0;
      start1     <= '0;
      len0       <= '0;
      total      <= '0;
    end else begin
      tx_start <= 1'b0;
      done     <= 1'b0;
      if (active && auto_btn) begin
        auto_on <= ~auto_on;
      end

      if (!active) begin
        // Abort silently: no done pulse, rom_addr keeps its last value.
        state      <= ST_IDLE;
        busy       <= 1'b0;
        empty_pend <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (empty_pend) begin
              done       <= 1'b1;
              busy       <= 1'b0;
              empty_pend <= 1'b0;
            end else if (launch) begin
              start0 <= tbl_start0;
              start1 <= tbl_start1;
              len0   <= tbl_len0;
              total  <= tbl_total;
              idx    <= '0;
              busy   <= 1'b1;
              if (tbl_total == '0) begin
                empty_pend <= 1'b1;
              end else begin
                state <= ST_WAIT_TICK;
              end
            end
          end
          ST_WAIT_TICK: begin
            if (char_tick && !tx_busy) begin
              rom_addr <= char_addr;
              dly      <= DLY_W'(START_DLY);
              state    <= ST_DELAY;
            end
          end
          ST_DELAY: begin
            if (dly <= DLY_W'(1)) begin
              tx_start <= 1'b1;
              state    <= ST_SEND;
            end else begin
              dly <= dly - DLY_W'(1);
            end
          end
          ST_SEND: begin
            idx       <= idx + 1'b1;
            seen_busy <= 1'b0;
            state     <= ST_WAIT_TX;
          end
          ST_WAIT_TX: begin
            // A serializer that never raises busy is released by the next char_tick.
            if (tx_busy) begin
              seen_busy <= 1'b1;
            end else if (seen_busy || char_tick) begin
              if (idx == total) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= ST_IDLE;
              end else begin
                state <= ST_WAIT_TICK;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_msg_sequencer.sv
// Randomized bench for msg_sequencer: expected character addresses come from a segment-table model.
module tb_msg_sequencer;

  localparam int ADDR_W    = 6;
  localparam int START_DLY = 3;

  logic              sysclk = 1'b0;
  logic              rst_n;
  logic              active;
  logic [3:0]        sel;
  logic              send;
  logic              auto_btn;
  logic              auto_tick;
  logic              char_tick = 1'b0;
  logic              tx_busy   = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic              tx_start;
  logic              busy;
  logic              done;
  logic              auto_on;

  always #5 sysclk = ~sysclk;

  msg_sequencer #(
    .SEL_W(4), .ADDR_W(ADDR_W), .LEN_W(6), .START_DLY(START_DLY)
  ) dut (
    .sysclk(sysclk), .rst_n(rst_n), .active(active), .sel(sel), .send(send),
    .auto_btn(auto_btn), .auto_tick(auto_tick), .char_tick(char_tick),
    .tx_busy(tx_busy), .rom_addr(rom_addr), .tx_start(tx_start), .busy(busy),
    .done(done), .auto_on(auto_on)
  );

  // Reference message table: segment starts and lengths per selector code.
  int t_s0 [16] = '{0, 0, 62, 13, 20, 0, 50, 24, 60, 0, 32, 19, 0, 8, 37, 1};
  int t_l0 [16] = '{0, 13, 4, 6, 4, 0, 5, 3, 2, 13, 5, 1, 0, 8, 2, 1};
  int t_s1 [16] = '{0, 0, 0, 0, 40, 45, 0, 24, 2, 32, 0, 0, 0, 56, 63, 2};
  int t_l1 [16] = '{0, 0, 0, 0, 3, 2, 0, 3, 2, 5, 13, 0, 0, 8, 3, 1};

  logic [ADDR_W-1:0] exp_q[$];
  int n_checks   = 0;
  int n_fail     = 0;
  int msg_starts = 0;
  int done_cnt   = 0;
  int ser_len    = 10;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void push_msg(input int code);
    for (int i = 0; i < t_l0[code]; i++) exp_q.push_back(ADDR_W'((t_s0[code] + i) % (1 << ADDR_W)));
    for (int i = 0; i < t_l1[code]; i++) exp_q.push_back(ADDR_W'((t_s1[code] + i) % (1 << ADDR_W)));
  endfunction

  // Monitor plus serializer model and char_tick source, all on the falling edge.
  initial begin
    int ser_cnt = 0;
    int addr_age = 0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic prev_start = 1'b0;
    forever begin
      @(negedge sysclk);
      if (rst_n === 1'b1) begin
        addr_age = (rom_addr != prev_addr) ? 0 : addr_age + 1;
        if (tx_start) begin
          check_eq("start_ser_idle", tx_busy, 0);
          check_eq("start_width", prev_start, 0);
          check_eq("addr_settle", addr_age >= START_DLY, 1);
          check_eq("start_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) check_eq("rom_addr", rom_addr, exp_q.pop_front());
          msg_starts++;
        end
        if (done) begin
          check_eq("done_after_last", exp_q.size(), 0);
          done_cnt++;
        end
        prev_addr  = rom_addr;
        prev_start = tx_start;
        if (tx_start) ser_cnt = ser_len;
        else if (ser_cnt > 0) ser_cnt--;
      end else begin
        ser_cnt    = 0;
        addr_age   = 0;
        prev_addr  = '0;
        prev_start = 1'b0;
      end
      tx_busy   = (ser_cnt > 0);
      char_tick = ($urandom_range(0, 3) == 0);
    end
  end

  task automatic launch_msg(input int code, input bit use_auto);
    @(negedge sysclk);
    sel = 4'(code);
    push_msg(code);
    if (use_auto) auto_tick = 1'b1;
    else send = 1'b1;
    @(negedge sysclk);
    send      = 1'b0;
    auto_tick = 1'b0;
  endtask

  // Waits for done; with noise, sel wiggles and extra sends arrive while characters remain.
  task automatic wait_msg(input bit noise);
    int start_done = done_cnt;
    int n = 0;
    while (done_cnt == start_done && n < 3000) begin
      @(negedge sysclk);
      send = 1'b0;
      if (noise && exp_q.size() > 0 && $urandom_range(0, 15) == 0) begin
        sel  = 4'($urandom_range(0, 15));
        send = 1'b1;
      end
      n++;
    end
    send = 1'b0;
    check_eq("msg_done_seen", done_cnt - start_done, 1);
  endtask

  task automatic run_msg(input int code, input bit use_auto, input bit noise);
    msg_starts = 0;
    launch_msg(code, use_auto);
    wait_msg(noise);
    check_eq($sformatf("starts_sel%0d", code), msg_starts, t_l0[code] + t_l1[code]);
    check_eq("busy_after_done", busy, 0);
    check_eq("queue_drained", exp_q.size(), 0);
  endtask

  task automatic pulse_auto_btn();
    @(negedge sysclk);
    auto_btn = 1'b1;
    @(negedge sysclk);
    auto_btn = 1'b0;
  endtask

  initial begin
    logic [ADDR_W-1:0] held_addr;
    int dcnt;
    int n;
    rst_n = 1'b0; active = 1'b1; sel = '0; send = 1'b0; auto_btn = 1'b0; auto_tick = 1'b0;
    repeat (3) @(negedge sysclk);
    check_eq("rst_rom_addr", rom_addr, 0);
    check_eq("rst_tx_start", tx_start, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_auto_on", auto_on, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge sysclk);

    ser_len = 10;
    run_msg(1, 1'b0, 1'b0);
    run_msg(9, 1'b0, 1'b0);
    run_msg(2, 1'b0, 1'b0);
    run_msg(14, 1'b0, 1'b0);

    // Empty message: busy for the launch cycle, then a lone done.
    msg_starts = 0;
    launch_msg(0, 1'b0);
    check_eq("empty_busy", busy, 1);
    check_eq("empty_done_early", done, 0);
    @(negedge sysclk);
    check_eq("empty_done", done, 1);
    check_eq("empty_busy_clr", busy, 0);
    @(negedge sysclk);
    check_eq("empty_done_once", done, 0);
    check_eq("empty_starts", msg_starts, 0);

    for (int k = 0; k < 14; k++) begin
      ser_len = $urandom_range(0, 12);
      run_msg($urandom_range(0, 15), 1'b0, 1'b1);
    end

    ser_len = 6;
    pulse_auto_btn();
    check_eq("auto_on_set", auto_on, 1);
    for (int k = 0; k < 3; k++) begin
      run_msg($urandom_range(1, 15), 1'b1, 1'b0);
      repeat (30) @(negedge sysclk);
    end
    msg_starts = 0;
    @(negedge sysclk);
    sel = 4'd4; push_msg(4); send = 1'b1; auto_tick = 1'b1;
    @(negedge sysclk);
    send = 1'b0; auto_tick = 1'b0;
    wait_msg(1'b0);
    repeat (80) @(negedge sysclk);
    check_eq("dual_launch_starts", msg_starts, 7);
    check_eq("dual_launch_idle", busy, 0);
    pulse_auto_btn();
    check_eq("auto_on_clr", auto_on, 0);
    msg_starts = 0;
    @(negedge sysclk);
    auto_tick = 1'b1;
    @(negedge sysclk);
    auto_tick = 1'b0;
    check_eq("auto_off_no_launch", busy, 0);
    repeat (40) @(negedge sysclk);
    check_eq("auto_off_starts", msg_starts, 0);

    // Abort after the fifth character.
    msg_starts = 0;
    launch_msg(9, 1'b0);
    n = 0;
    while (msg_starts < 5 && n < 2000) begin @(negedge sysclk); n++; end
    check_eq("abort_reach5", msg_starts, 5);
    active = 1'b0;
    held_addr = rom_addr;
    dcnt = done_cnt;
    exp_q.delete();
    @(negedge sysclk);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_tx_start", tx_start, 0);
    auto_btn = 1'b1;
    @(negedge sysclk);
    auto_btn = 1'b0;
    check_eq("inactive_auto_btn", auto_on, 0);
    repeat (60) @(negedge sysclk);
    check_eq("abort_no_done", done_cnt - dcnt, 0);
    check_eq("abort_addr_hold", rom_addr, held_addr);
    check_eq("abort_no_more_starts", msg_starts, 5);
    active = 1'b1;
    repeat (5) @(negedge sysclk);
    run_msg(9, 1'b0, 1'b0);

    // Asynchronous reset while the first character is settling.
    pulse_auto_btn();
    msg_starts = 0;
    launch_msg(3, 1'b0);
    n = 0;
    while (rom_addr != 6'd13 && n < 500) begin @(negedge sysclk); n++; end
    check_eq("delay_reached", rom_addr, 13);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_eq("arst_rom_addr", rom_addr, 0);
    check_eq("arst_tx_start", tx_start, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_done", done, 0);
    check_eq("arst_auto_on", auto_on, 0);
    repeat (8) @(negedge sysclk);
    rst_n = 1'b1;
    repeat (30) @(negedge sysclk);
    check_eq("arst_no_start", msg_starts, 0);
    check_eq("arst_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/msg_sequencer.md
Name: msg_sequencer

Overview:
- Parametrised successor to the switch-selected word sender.
- Maps a selector code to a message made of up to two ROM segments.
- Walks the message one character at a time, pulses the serializer start, and waits on serializer busy instead of relying on fixed pacing.
- Sits between the debouncers/clock dividers and the serial transmitter; adds reset, abort, busy/done status and generalised widths.

Parameters:
- SEL_W, 4, selector width; 2**SEL_W message codes.
- ADDR_W, 6, character ROM address width.
- LEN_W, 6, per-segment length width.
- START_DLY, 3, cycles between address update and tx_start (ROM/data settle).

Ports:
- sysclk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- active  in  1  block enable; low forces abort to IDLE.
- sel  in  SEL_W  message selector (switches), sampled only at launch.
- send  in  1  one-cycle debounced manual send pulse.
- auto_btn  in  1  one-cycle debounced pulse toggling auto mode.
- auto_tick  in  1  one-cycle pulse launching a send when auto mode is on.
- char_tick  in  1  one-cycle character pacing pulse.
- tx_busy  in  1  serializer busy.
- rom_addr  out  ADDR_W  character ROM address.
- tx_start  out  1  one-cycle serializer start.
- busy  out  1  high from launch until the last character completes.
- done  out  1  one-cycle pulse after the last character.
- auto_on  out  1  auto mode state.

Behaviour:
- Reset values: rom_addr=0, tx_start=0, busy=0, done=0, auto_on=0, state=IDLE.
- auto_on toggles on auto_btn whenever active=1, in any state.
- launch = send | (auto_tick & auto_on).
- Segment lookup: combinational msg_table(sel) returns {start0, len0, start1, len1}, each len zero or more.
  - Total length = len0 + len1.
  - Character index i maps to start0+i when i<len0, otherwise start1+(i-len0).
  - All address arithmetic is modulo 2**ADDR_W (wraps).
- sel and the table outputs are latched at launch; later sel changes do not affect the message in flight.
- IDLE:
  - On launch, latch the table, set idx=0 and busy=1.
  - If total==0, pulse done the next cycle, clear busy and stay in IDLE.
  - Otherwise go to WAIT_TICK.
- WAIT_TICK: on char_tick with tx_busy=0, register rom_addr for idx, load the delay counter and go to DELAY. A char_tick seen while tx_busy=1 is ignored.
- DELAY: count down START_DLY cycles, then go to SEND.
- SEND: tx_start=1 for exactly one cycle, idx++, go to WAIT_TX.
- WAIT_TX:
  - Wait for tx_busy high then low. If tx_busy stays low, the first char_tick after SEND is treated as completion.
  - If idx==total, pulse done, clear busy and go to IDLE. Otherwise go to WAIT_TICK.
- Latency: launch to first tx_start is at least 1 + (cycles to next char_tick) + START_DLY + 1.
- A launch while busy=1 is ignored; no retrigger or restart.
- Same-cycle send and auto_tick count as a single launch.
- active=0 mid-message:
  - Next cycle goes to IDLE with busy=0 and tx_start=0.
  - No done pulse.
  - rom_addr holds.
- Async reset mid-message: all outputs go to reset values immediately.

Decomposition:
- Shared package msg_pkg: state enum, segment record type {start, len}, and the message table contents as constants.
- Natural sub-module: msg_table (combinational sel -> two segments). It replaces the per-code case logic and lets new messages be added without touching the FSM.

Test Plan:
- sel=4'b0001 (seg0 start=0 len=13, seg1 len=0), send pulse, serializer model busy 10 cycles -> 13 tx_start pulses at rom_addr 0..12, then one done pulse, busy low.
- sel=4'b1001 (seg0 0/13, seg1 32/5) -> addresses 0..12 then 32..36, 18 starts, done once.
- Segment at start=62 len=4 with ADDR_W=6 -> addresses 62,63,0,1.
- auto_btn, then 3 auto_tick pulses spaced longer than a message -> 3 full messages. A second auto_btn, then auto_tick -> no launch. send pulses while busy -> no effect.
- active dropped after the 5th tx_start -> busy=0 next cycle, no done pulse, no further tx_start. A subsequent send restarts from idx 0.
- rst_n asserted mid-DELAY -> tx_start never fires, all outputs at reset values. Empty message (total=0) -> done pulse, zero tx_start.
